// File: rtl/bus_port_arbiter_pkg.sv
// Shared bus types for the instruction/data port arbiter.
// Bus widths, access sizes, FSM state and owner encodings.
package bus_port_arbiter_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int INST_W = 32;
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic              addr_ok;
        logic              data_ok;
        logic [INST_W-1:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        msize_t            size;
        logic [STRB_W-1:0] strobe;
        logic [DATA_W-1:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic              addr_ok;
        logic              data_ok;
        logic [DATA_W-1:0] data;
    } dbus_resp_t;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        msize_t            size;
        logic [STRB_W-1:0] strobe;
        logic [DATA_W-1:0] data;
    } mport_req_t;

    typedef struct packed {
        logic              addr_ok;
        logic              data_ok;
        logic [DATA_W-1:0] data;
    } mport_resp_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        OWN_I = 2'd1,
        OWN_D = 2'd2
    } owner_t;

endpackage

// File: rtl/bus_port_arbiter.sv
// Serialises instruction and data requests onto one single-beat memory port,
// with data priority bounded by a starvation counter for fetches.
module bus_port_arbiter
    import bus_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 1,
    parameter int CNT_W        = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  ibus_req_t   ireq,
    output ibus_resp_t  iresp,
    input  dbus_req_t   dreq,
    output dbus_resp_t  dresp,
    output mport_req_t  mreq,
    input  mport_resp_t mresp,
    output logic        busy
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    arb_state_t       state, state_nxt;
    owner_t           owner, owner_nxt;
    mport_req_t       lat, lat_nxt;
    logic [CNT_W-1:0] starve_cnt, cnt_nxt;
    logic             forced;
    logic             grant_i;
    logic             grant_d;
    logic             done;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= NONE;
            lat        <= '0;
            starve_cnt <= '0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            lat        <= lat_nxt;
            starve_cnt <= cnt_nxt;
        end
    end

    // Grant, starvation tracking and FSM transitions.
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        lat_nxt   = lat;
        cnt_nxt   = starve_cnt;
        forced    = 1'b0;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                forced = ireq.valid && (starve_cnt == LIMIT);
                if (dreq.valid && !forced) begin
                    grant_d = 1'b1;
                end else if (ireq.valid) begin
                    grant_i = 1'b1;
                end
                if (grant_d) begin
                    lat_nxt.valid  = 1'b0;
                    lat_nxt.addr   = dreq.addr;
                    lat_nxt.size   = dreq.size;
                    lat_nxt.strobe = dreq.strobe;
                    lat_nxt.data   = dreq.data;
                    owner_nxt      = OWN_D;
                    state_nxt      = REQ;
                    if (!ireq.valid) begin
                        cnt_nxt = '0;
                    end else if (starve_cnt < LIMIT) begin
                        cnt_nxt = starve_cnt + 1'b1;
                    end
                end else if (grant_i) begin
                    lat_nxt.valid  = 1'b0;
                    lat_nxt.addr   = ireq.addr;
                    lat_nxt.size   = MSIZE4;
                    lat_nxt.strobe = '0;
                    lat_nxt.data   = '0;
                    owner_nxt      = OWN_I;
                    state_nxt      = REQ;
                    cnt_nxt        = '0;
                end
            end
            REQ: begin
                if (mresp.addr_ok && mresp.data_ok) begin
                    done = 1'b1;
                end else if (mresp.addr_ok) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                done = mresp.data_ok;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (done) begin
            state_nxt = IDLE;
            owner_nxt = NONE;
        end
    end

    // A withdrawn requester gets no response; the port still completes.
    always_comb begin
        mreq  = '0;
        iresp = '0;
        dresp = '0;
        if (state == REQ) begin
            mreq       = lat;
            mreq.valid = 1'b1;
        end
        if (done && owner == OWN_I && ireq.valid) begin
            iresp.addr_ok = 1'b1;
            iresp.data_ok = 1'b1;
            iresp.data    = mresp.data[INST_W-1:0];
        end
        if (done && owner == OWN_D && dreq.valid) begin
            dresp.addr_ok = 1'b1;
            dresp.data_ok = 1'b1;
            dresp.data    = mresp.data;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_bus_port_arbiter.sv
// Directed checks of grant order, latency, starvation bound,
// reset abort and withdrawn-request handling.
module tb_bus_port_arbiter;
    import bus_port_arbiter_pkg::*;

    logic        clk;
    logic        reset;
    ibus_req_t   ireq;
    ibus_resp_t  iresp;
    dbus_req_t   dreq;
    dbus_resp_t  dresp;
    mport_req_t  mreq;
    mport_resp_t mresp;
    logic        busy;

    int total = 0;
    int bad   = 0;

    bus_port_arbiter #(.STARVE_LIMIT(1), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .ireq  (ireq),
        .iresp (iresp),
        .dreq  (dreq),
        .dresp (dresp),
        .mreq  (mreq),
        .mresp (mresp),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic mem(input logic a, input logic d, input logic [63:0] v);
        mresp.addr_ok = a;
        mresp.data_ok = d;
        mresp.data    = v;
    endtask

    initial begin
        reset = 1'b1;
        ireq  = '0;
        dreq  = '0;
        mresp = '0;
        tick();
        tick();
        settle();
        chk("rst_busy", busy, 0);
        chk("rst_mvalid", mreq.valid, 0);
        chk("rst_iresp", iresp, 0);
        chk("rst_dresp", dresp, 0);

        // Test 1: single fetch with split address/data phases.
        reset = 1'b0;
        ireq.valid = 1'b1;
        ireq.addr  = 32'h8000_0000;
        settle();
        chk("t1_c0_mvalid", mreq.valid, 0);
        tick();
        settle();
        chk("t1_c1_mvalid", mreq.valid, 1);
        chk("t1_c1_addr", mreq.addr, 64'h8000_0000);
        chk("t1_c1_strobe", mreq.strobe, 0);
        chk("t1_c1_size", mreq.size, MSIZE4);
        tick();
        mem(1, 0, 0);
        settle();
        chk("t1_c2_mvalid", mreq.valid, 1);
        chk("t1_c2_idok", iresp.data_ok, 0);
        tick();
        mem(0, 0, 0);
        settle();
        chk("t1_c3_mvalid", mreq.valid, 0);
        chk("t1_c3_busy", busy, 1);
        chk("t1_c3_idok", iresp.data_ok, 0);
        tick();
        mem(0, 1, 64'h13);
        settle();
        chk("t1_c4_idok", iresp.data_ok, 1);
        chk("t1_c4_iaok", iresp.addr_ok, 1);
        chk("t1_c4_idata", iresp.data, 64'h13);
        chk("t1_c4_ddok", dresp.data_ok, 0);
        ireq.valid = 1'b0;
        tick();
        mem(0, 0, 0);
        settle();
        chk("t1_c5_busy", busy, 0);
        chk("t1_c5_idok", iresp.data_ok, 0);

        // Test 2 + 4: simultaneous requests, same-cycle completions.
        ireq.valid  = 1'b1;
        ireq.addr   = 32'h8000_0040;
        dreq.valid  = 1'b1;
        dreq.addr   = 32'h8000_1000;
        dreq.size   = MSIZE8;
        dreq.strobe = 8'hFF;
        dreq.data   = 64'hDEAD_BEEF_0000_0001;
        tick();
        mem(1, 1, 64'hAAAA_5555_1234_5678);
        settle();
        chk("t2_c1_addr", mreq.addr, 64'h8000_1000);
        chk("t2_c1_strobe", mreq.strobe, 8'hFF);
        chk("t2_c1_wdata", mreq.data, 64'hDEAD_BEEF_0000_0001);
        chk("t2_c1_ddok", dresp.data_ok, 1);
        chk("t2_c1_ddata", dresp.data, 64'hAAAA_5555_1234_5678);
        chk("t2_c1_idok", iresp.data_ok, 0);
        dreq.valid = 1'b0;
        tick();
        mem(0, 0, 0);
        settle();
        chk("t4_c2_busy", busy, 0);
        chk("t2_c2_mvalid", mreq.valid, 0);
        tick();
        mem(1, 1, 64'h0000_0000_0000_0093);
        settle();
        chk("t2_c3_addr", mreq.addr, 64'h8000_0040);
        chk("t2_c3_strobe", mreq.strobe, 0);
        chk("t2_c3_idok", iresp.data_ok, 1);
        chk("t2_c3_idata", iresp.data, 64'h93);
        chk("t2_c3_ddok", dresp.data_ok, 0);
        ireq.valid = 1'b0;
        tick();
        mem(0, 0, 0);
        settle();
        chk("t2_c4_busy", busy, 0);

        // Test 3: both held valid; starvation bound alternates grants.
        ireq.valid  = 1'b1;
        ireq.addr   = 32'h8000_0100;
        dreq.valid  = 1'b1;
        dreq.addr   = 32'h8000_2000;
        dreq.strobe = 8'h0F;
        for (int k = 0; k < 4; k++) begin
            tick();
            mem(1, 1, 64'(k));
            settle();
            if (k % 2 == 0) begin
                chk($sformatf("t3_g%0d_D", k), mreq.addr, 64'h8000_2000);
                chk($sformatf("t3_g%0d_dok", k), dresp.data_ok, 1);
            end else begin
                chk($sformatf("t3_g%0d_I", k), mreq.addr, 64'h8000_0100);
                chk($sformatf("t3_g%0d_iok", k), iresp.data_ok, 1);
            end
            if (k == 3) begin
                ireq.valid = 1'b0;
                dreq.valid = 1'b0;
            end
            tick();
            mem(0, 0, 0);
            settle();
            chk($sformatf("t3_g%0d_idle", k), busy, 0);
        end

        // Test 5: reset while waiting on a data read.
        dreq.valid  = 1'b1;
        dreq.addr   = 32'h8000_3000;
        dreq.strobe = 8'h00;
        tick();
        mem(1, 0, 0);
        settle();
        chk("t5_c1_mvalid", mreq.valid, 1);
        tick();
        mem(0, 0, 0);
        settle();
        chk("t5_c2_busy", busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mem(0, 1, 64'h77);
        settle();
        chk("t5_c3_busy", busy, 0);
        chk("t5_c3_mvalid", mreq.valid, 0);
        chk("t5_c3_ddok", dresp.data_ok, 0);
        dreq.valid = 1'b0;
        tick();
        mem(0, 0, 0);
        settle();
        chk("t5_c4_busy", busy, 0);

        // Test 6: data request withdrawn during WAIT; fields latched.
        dreq.valid = 1'b1;
        dreq.addr  = 32'h8000_4000;
        tick();
        mem(1, 0, 0);
        dreq.addr = 32'h8000_5000;
        settle();
        chk("t6_c1_latched", mreq.addr, 64'h8000_4000);
        tick();
        mem(0, 0, 0);
        dreq.valid = 1'b0;
        settle();
        chk("t6_c2_busy", busy, 1);
        tick();
        mem(0, 1, 64'h55);
        settle();
        chk("t6_c3_ddok", dresp.data_ok, 0);
        chk("t6_c3_ddata", dresp.data, 0);
        chk("t6_c3_idok", iresp.data_ok, 0);
        tick();
        mem(0, 0, 0);
        settle();
        chk("t6_c4_busy", busy, 0);
        chk("t6_c4_mvalid", mreq.valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
